// File: rtl/dc_pred_stream.sv
// DC intra predictor for NUM_CH planes: captures top/left edges, sums LANES samples
// per edge per cycle, rounds by edge availability, then streams dc-filled rows.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start; edges and mode captured on accept
// ST_ACC   | K = BLOCK_SIZE/LANES cycles summing available edge samples
// ST_ROUND | one cycle: normalise sums into dc_out per channel
// ST_OUT   | rows presented over valid/ready; done pulses after last row
module dc_pred_stream #(
  parameter int BIT_WIDTH  = 8,
  parameter int BLOCK_SIZE = 8,
  parameter int NUM_CH     = 2,
  parameter int LANES      = 2,
  parameter int BLOCK_NUM  = 10
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    start,
  input  logic                                    force_none,
  input  logic [BLOCK_NUM-1:0]                    x,
  input  logic [BLOCK_NUM-1:0]                    y,
  input  logic [NUM_CH*BLOCK_SIZE*BIT_WIDTH-1:0]  top,
  input  logic [NUM_CH*BLOCK_SIZE*BIT_WIDTH-1:0]  left,
  output logic                                    busy,
  output logic [NUM_CH*BIT_WIDTH-1:0]             dc_out,
  output logic                                    row_valid,
  input  logic                                    row_ready,
  output logic [$clog2(BLOCK_SIZE)-1:0]           row_idx,
  output logic [NUM_CH*BLOCK_SIZE*BIT_WIDTH-1:0]  row_data,
  output logic                                    done
);

  localparam int S      = $clog2(BLOCK_SIZE);
  localparam int K      = BLOCK_SIZE / LANES;
  localparam int KW     = (K > 1) ? $clog2(K) : 1;
  localparam int ACC_W  = BIT_WIDTH + S + 1;
  localparam int EDGE_W = NUM_CH * BLOCK_SIZE * BIT_WIDTH;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACC   = 2'd1;
  localparam logic [1:0] ST_ROUND = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  localparam logic [KW-1:0]        K_LAST   = KW'(K - 1);
  localparam logic [KW-1:0]        K_ONE    = KW'(1);
  localparam logic [S-1:0]         ROW_LAST = S'(BLOCK_SIZE - 1);
  localparam logic [S-1:0]         ROW_ONE  = S'(1);
  localparam logic [BIT_WIDTH-1:0] DC_MID   = {1'b1, {(BIT_WIDTH-1){1'b0}}};

  logic [1:0]                            state_q, state_d;
  logic [EDGE_W-1:0]                     top_q, top_d;
  logic [EDGE_W-1:0]                     left_q, left_d;
  logic                                  use_top_q, use_top_d;
  logic                                  use_left_q, use_left_d;
  logic [NUM_CH-1:0][ACC_W-1:0]          acc_q, acc_d;
  logic [KW-1:0]                         k_q, k_d;
  logic [NUM_CH-1:0][BIT_WIDTH-1:0]      dc_q, dc_d;
  logic [S-1:0]                          row_idx_q, row_idx_d;
  logic                                  row_valid_q, row_valid_d;
  logic                                  done_q, done_d;

  logic [NUM_CH-1:0][ACC_W-1:0]          lane_sum;
  logic [NUM_CH-1:0][BIT_WIDTH-1:0]      dc_calc;
  logic                                  avail_top, avail_left;

  // Unavailable edges simply contribute nothing to the per-cycle lane sum.
  always_comb begin
    lane_sum = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int l = 0; l < LANES; l++) begin
        if (use_top_q)
          lane_sum[c] = lane_sum[c] + ACC_W'(top_q[(c*BLOCK_SIZE + int'(k_q)*LANES + l)*BIT_WIDTH +: BIT_WIDTH]);
        if (use_left_q)
          lane_sum[c] = lane_sum[c] + ACC_W'(left_q[(c*BLOCK_SIZE + int'(k_q)*LANES + l)*BIT_WIDTH +: BIT_WIDTH]);
      end
    end
  end

  always_comb begin
    dc_calc = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      case ({use_top_q, use_left_q})
        2'b11:        dc_calc[c] = BIT_WIDTH'((acc_q[c] + ACC_W'(BLOCK_SIZE)) >> (S + 1));
        2'b10, 2'b01: dc_calc[c] = BIT_WIDTH'((acc_q[c] + ACC_W'(BLOCK_SIZE / 2)) >> S);
        default:      dc_calc[c] = DC_MID;
      endcase
    end
  end

  assign avail_top  = !force_none && (y != '0);
  assign avail_left = !force_none && (x != '0);

  always_comb begin
    state_d     = state_q;
    top_d       = top_q;
    left_d      = left_q;
    use_top_d   = use_top_q;
    use_left_d  = use_left_q;
    acc_d       = acc_q;
    k_d         = k_q;
    dc_d        = dc_q;
    row_idx_d   = row_idx_q;
    row_valid_d = row_valid_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          top_d      = top;
          left_d     = left;
          use_top_d  = avail_top;
          use_left_d = avail_left;
          acc_d      = '0;
          k_d        = '0;
          state_d    = (avail_top || avail_left) ? ST_ACC : ST_ROUND;
        end
      end
      ST_ACC: begin
        for (int c = 0; c < NUM_CH; c++)
          acc_d[c] = acc_q[c] + lane_sum[c];
        k_d = k_q + K_ONE;
        if (k_q == K_LAST)
          state_d = ST_ROUND;
      end
      ST_ROUND: begin
        dc_d        = dc_calc;
        row_idx_d   = '0;
        row_valid_d = 1'b1;
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        if (row_ready) begin
          if (row_idx_q == ROW_LAST) begin
            row_valid_d = 1'b0;
            row_idx_d   = '0;
            done_d      = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            row_idx_d = row_idx_q + ROW_ONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      top_q       <= '0;
      left_q      <= '0;
      use_top_q   <= 1'b0;
      use_left_q  <= 1'b0;
      acc_q       <= '0;
      k_q         <= '0;
      dc_q        <= '0;
      row_idx_q   <= '0;
      row_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      top_q       <= top_d;
      left_q      <= left_d;
      use_top_q   <= use_top_d;
      use_left_q  <= use_left_d;
      acc_q       <= acc_d;
      k_q         <= k_d;
      dc_q        <= dc_d;
      row_idx_q   <= row_idx_d;
      row_valid_q <= row_valid_d;
      done_q      <= done_d;
    end
  end

  // Row data is only driven while a row is offered, so it reads zero after reset.
  always_comb begin
    row_data = '0;
    for (int c = 0; c < NUM_CH; c++)
      for (int i = 0; i < BLOCK_SIZE; i++)
        row_data[(c*BLOCK_SIZE + i)*BIT_WIDTH +: BIT_WIDTH] = row_valid_q ? dc_q[c] : '0;
  end

  assign busy      = (state_q != ST_IDLE);
  assign dc_out    = dc_q;
  assign row_valid = row_valid_q;
  assign row_idx   = row_idx_q;
  assign done      = done_q;

endmodule
